// File: rtl/lr35902_pkg.sv
// Shared constants for the LR35902 interrupt path: source indices,
// vector layout and the IF/IE register select values.
package lr35902_pkg;

    localparam int VBLANK = 0;
    localparam int STAT   = 1;
    localparam int TIMER  = 2;
    localparam int SERIAL = 3;
    localparam int JOYPAD = 4;

    localparam logic [7:0] IRQ_VEC_BASE   = 8'h40;
    localparam logic [7:0] IRQ_VEC_STRIDE = 8'd8;

    localparam logic IF = 1'b0;
    localparam logic IE = 1'b1;

    function automatic logic [7:0] irq_vector(input logic [2:0] idx);
        return IRQ_VEC_BASE + IRQ_VEC_STRIDE * {5'd0, idx};
    endfunction

endpackage

// File: rtl/lr35902_irq_prio.sv
// Lowest-index-first priority encoder for the five interrupt sources.
// Ports: req[4:0] in; valid, idx[2:0], vec[7:0] out (vec = 0 when idle).
module lr35902_irq_prio
    import lr35902_pkg::*;
(
    input  logic [4:0] req,
    output logic       valid,
    output logic [2:0] idx,
    output logic [7:0] vec
);

    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        // Scan downward so the lowest set bit is the last assignment.
        for (int i = 4; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 3'(i);
            end
        end
        vec = valid ? irq_vector(idx) : 8'h00;
    end

endmodule

// File: rtl/lr35902_irqctl.sv
// Interrupt controller: IF/IE registers on the CPU bus, request capture,
// prioritised request/vector to the core and IF clear on acknowledge.
// Ports: clk, reset (sync, active-high); bus din/dout/adr/read/write;
// irq_in[4:0] request pulses; ack from core; cpu_irq, cpu_vector to core.
module lr35902_irqctl
    import lr35902_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       adr,
    input  logic       read,
    input  logic       write,
    input  logic [4:0] irq_in,
    input  logic       ack,
    output logic       cpu_irq,
    output logic [7:0] cpu_vector
);

    logic [4:0] if_q, if_d;
    logic [7:0] ie_q, ie_d;
    logic [7:0] dout_q, dout_d;
    logic       wp_q, wp_d;
    logic       wadr_q, wadr_d;
    logic [7:0] wdin_q, wdin_d;
    logic       read_prev_q, read_prev_d;
    logic       write_prev_q, write_prev_d;

    logic       rd_trig;
    logic       wr_trig;
    logic       pr_valid;
    logic [2:0] pr_idx;
    logic [7:0] pr_vec;

    lr35902_irq_prio u_prio (
        .req   (if_q & ie_q[4:0]),
        .valid (pr_valid),
        .idx   (pr_idx),
        .vec   (pr_vec)
    );

    assign rd_trig = read & ~read_prev_q;
    assign wr_trig = ~write & write_prev_q;

    always_comb begin
        if_d         = if_q;
        ie_d         = ie_q;
        dout_d       = dout_q;
        wp_d         = wp_q;
        wadr_d       = wadr_q;
        wdin_d       = wdin_q;
        read_prev_d  = read;
        write_prev_d = write;

        // Latched write lands one cycle after the falling edge.
        if (wp_q) begin
            wp_d = 1'b0;
            if (wadr_q == IE) begin
                ie_d = wdin_q;
            end else begin
                if_d = wdin_q[4:0];
            end
        end

        // Ack clears the bit the core saw, not one chosen after the write.
        if (ack && pr_valid) begin
            if_d = if_d & ~(5'b00001 << pr_idx);
        end

        // New requests are never lost to a clear in the same cycle.
        if_d = if_d | irq_in;

        if (wr_trig) begin
            wp_d   = 1'b1;
            wadr_d = adr;
            wdin_d = din;
        end

        if (rd_trig) begin
            dout_d = (adr == IE) ? ie_q : {3'b111, if_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_q         <= 5'd0;
            ie_q         <= 8'h00;
            dout_q       <= 8'h00;
            wp_q         <= 1'b0;
            wadr_q       <= 1'b0;
            wdin_q       <= 8'h00;
            read_prev_q  <= 1'b0;
            write_prev_q <= 1'b0;
        end else begin
            if_q         <= if_d;
            ie_q         <= ie_d;
            dout_q       <= dout_d;
            wp_q         <= wp_d;
            wadr_q       <= wadr_d;
            wdin_q       <= wdin_d;
            read_prev_q  <= read_prev_d;
            write_prev_q <= write_prev_d;
        end
    end

    assign dout       = dout_q;
    assign cpu_irq    = pr_valid;
    assign cpu_vector = pr_vec;

endmodule

// File: tb/tb_lr35902_irqctl.sv
// Bench for lr35902_irqctl: directed scenarios plus random bus/irq/ack
// traffic compared each cycle against a transaction-level model.
module tb_lr35902_irqctl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic [7:0] dout;
    logic       adr;
    logic       read;
    logic       write;
    logic [4:0] irq_in;
    logic       ack;
    logic       cpu_irq;
    logic [7:0] cpu_vector;

    int total = 0;
    int bad   = 0;
    bit model_chk = 1'b0;

    lr35902_irqctl dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .dout       (dout),
        .adr        (adr),
        .read       (read),
        .write      (write),
        .irq_in     (irq_in),
        .ack        (ack),
        .cpu_irq    (cpu_irq),
        .cpu_vector (cpu_vector)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Reference model: register contents plus a queue of bus writes
    // waiting to be committed.
    logic [4:0] m_if;
    logic [7:0] m_ie;
    logic [7:0] m_dout;
    logic [8:0] m_wq[$];
    logic       m_rprev;
    logic       m_wprev;

    function automatic int m_pending_idx(input logic [4:0] f,
                                         input logic [7:0] e);
        for (int i = 0; i < 5; i++)
            if (f[i] && e[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] m_vec();
        int i;
        i = m_pending_idx(m_if, m_ie);
        return (i < 0) ? 8'h00 : 8'(64 + 8 * i);
    endfunction

    always @(posedge clk) begin
        logic [4:0] nf;
        logic [7:0] ne;
        logic [8:0] w;
        int         k;
        if (reset) begin
            m_if = 0; m_ie = 0; m_dout = 0;
            m_wq.delete();
            m_rprev = 0; m_wprev = 0;
        end else begin
            nf = m_if;
            ne = m_ie;
            k  = m_pending_idx(m_if, m_ie);
            if (m_wq.size() > 0) begin
                w = m_wq.pop_front();
                if (w[8]) ne = w[7:0];
                else      nf = w[4:0];
            end
            if (ack && k >= 0) nf[k] = 1'b0;
            nf = nf | irq_in;
            if (read && !m_rprev)
                m_dout = adr ? m_ie : {3'b111, m_if};
            if (!write && m_wprev)
                m_wq.push_back({adr, din});
            m_rprev = read;
            m_wprev = write;
            m_if = nf;
            m_ie = ne;
        end
    end

    always @(negedge clk) begin
        if (model_chk) begin
            chk("m_irq", {7'd0, cpu_irq}, {7'd0, m_vec() != 8'h00});
            chk("m_vec", cpu_vector, m_vec());
            chk("m_dout", dout, m_dout);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic a, input logic [7:0] d,
                      input logic [4:0] apply_irq);
        adr = a; din = d; write = 1'b1;
        tick(); tick();
        write = 1'b0;
        tick();
        irq_in = apply_irq;
        tick();
        irq_in = 5'd0;
    endtask

    task automatic rd(input logic a, output logic [7:0] v);
        adr = a; read = 1'b1;
        tick();
        v = dout;
        read = 1'b0;
        tick();
    endtask

    logic [7:0] v;
    logic [7:0] exp_seq[5];

    initial begin
        reset = 1'b1; din = 0; adr = 0; read = 0; write = 0;
        irq_in = 0; ack = 0;
        tick(); tick();
        reset = 1'b0;
        model_chk = 1'b1;

        chk("rst_irq", {7'd0, cpu_irq}, 8'h00);
        chk("rst_vec", cpu_vector, 8'h00);
        chk("rst_dout", dout, 8'h00);
        rd(1'b0, v); chk("rst_if", v, 8'he0);
        rd(1'b1, v); chk("rst_ie", v, 8'h00);

        wr(1'b1, 8'h04, 5'd0);
        irq_in = 5'h04;
        tick();
        irq_in = 5'h00;
        chk("tmr_irq", {7'd0, cpu_irq}, 8'h01);
        chk("tmr_vec", cpu_vector, 8'h50);
        rd(1'b0, v); chk("tmr_if", v, 8'he4);

        wr(1'b1, 8'h1f, 5'd0);
        wr(1'b0, 8'h1f, 5'd0);
        chk("all_vec", cpu_vector, 8'h40);
        exp_seq = '{8'h48, 8'h50, 8'h58, 8'h60, 8'h00};
        for (int i = 0; i < 5; i++) begin
            ack = 1'b1;
            tick();
            ack = 1'b0;
            chk($sformatf("ack_vec%0d", i), cpu_vector, exp_seq[i]);
            tick();
        end
        chk("ack_irq", {7'd0, cpu_irq}, 8'h00);
        rd(1'b0, v); chk("ack_if", v, 8'he0);

        wr(1'b0, 8'h00, 5'h04);
        rd(1'b0, v); chk("wr_vs_irq", v, 8'he4);
        chk("ack_pre", cpu_vector, 8'h50);
        ack = 1'b1; irq_in = 5'h04;
        tick();
        ack = 1'b0; irq_in = 5'h00;
        chk("ack_vs_irq", cpu_vector, 8'h50);
        rd(1'b0, v); chk("ack_vs_irq_if", v, 8'he4);

        wr(1'b1, 8'h00, 5'd0);
        wr(1'b0, 8'h00, 5'd0);
        irq_in = 5'h1f;
        tick();
        irq_in = 5'h00;
        chk("mask_irq", {7'd0, cpu_irq}, 8'h00);
        rd(1'b0, v); chk("mask_if", v, 8'hff);
        wr(1'b1, 8'h10, 5'd0);
        chk("joy_vec", cpu_vector, 8'h60);
        chk("joy_irq", {7'd0, cpu_irq}, 8'h01);

        adr = 1'b0; din = 8'h1f; write = 1'b1;
        tick(); tick();
        write = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        rd(1'b0, v); chk("rst_wr_if", v, 8'he0);
        rd(1'b1, v); chk("rst_wr_ie", v, 8'h00);

        for (int c = 0; c < 3000; c++) begin
            reset  = ($urandom_range(0, 199) == 0);
            read   = $urandom_range(0, 1);
            if ($urandom_range(0, 2) == 0) write = ~write;
            adr    = $urandom_range(0, 1);
            din    = 8'($urandom);
            irq_in = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
            ack    = ($urandom_range(0, 3) == 0);
            tick();
        end
        reset = 0; read = 0; write = 0; irq_in = 0; ack = 0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
